// File: rtl/wb_commit_buffer.sv
// In-order writeback buffer: queues up to two results per cycle and drains up to
// two per cycle onto the dual register-file write ports, never two writes to one rd.
// Optional macro WB_FWD_EN adds a combinational two-port lookup of pending results.
module wb_commit_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in0_valid,
    input  logic                    in0_we,
    input  logic [AW-1:0]           in0_rd,
    input  logic [DW-1:0]           in0_data,
    input  logic                    in1_valid,
    input  logic                    in1_we,
    input  logic [AW-1:0]           in1_rd,
    input  logic [DW-1:0]           in1_data,
    output logic                    in_ready,
    input  logic                    hold,
    output logic [AW-1:0]           rd1,
    output logic [DW-1:0]           wb_data1,
    output logic                    wb_we1,
    output logic [AW-1:0]           rd2,
    output logic [DW-1:0]           wb_data2,
    output logic                    wb_we2,
`ifdef WB_FWD_EN
    input  logic [AW-1:0]           q_rs1,
    input  logic [AW-1:0]           q_rs2,
    output logic                    q_hit1,
    output logic                    q_hit2,
    output logic [DW-1:0]           q_data1,
    output logic [DW-1:0]           q_data2,
`endif
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] rd_mem_q   [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [DW-1:0] wb_data1_q, wb_data1_d, wb_data2_q, wb_data2_d;
    logic          wb_we1_q, wb_we1_d, wb_we2_q, wb_we2_d;

    logic          live0_c, live1_c, push_en_c;
    logic [1:0]    n_push_c, n_pop_c;
    logic [PW-1:0] head1_c, slot1_c;

    // Lanes that do not actually write a non-zero register are dropped here
    assign live0_c   = in0_valid && in0_we && (in0_rd != '0);
    assign live1_c   = in1_valid && in1_we && (in1_rd != '0);
    assign push_en_c = in_ready;
    assign n_push_c  = push_en_c ? (2'(live0_c) + 2'(live1_c)) : 2'd0;
    assign slot1_c   = wr_ptr_q + PW'(live0_c);
    assign head1_c   = rd_ptr_q + PW'(1);

    // Room for a full pair, judged from registered occupancy only
    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));

    assign rd1      = rd1_q;
    assign wb_data1 = wb_data1_q;
    assign wb_we1   = wb_we1_q;
    assign rd2      = rd2_q;
    assign wb_data2 = wb_data2_q;
    assign wb_we2   = wb_we2_q;

    // Pop two only when the pair targets different registers
    always_comb begin
        n_pop_c = 2'd0;
        if (!hold) begin
            if ((count_q >= CW'(2)) && (rd_mem_q[rd_ptr_q] != rd_mem_q[head1_c])) begin
                n_pop_c = 2'd2;
            end else if (count_q != '0) begin
                n_pop_c = 2'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(n_push_c);
        rd_ptr_d   = rd_ptr_q + PW'(n_pop_c);
        count_d    = count_q + CW'(n_push_c) - CW'(n_pop_c);
        rd1_d      = rd1_q;
        wb_data1_d = wb_data1_q;
        wb_we1_d   = 1'b0;
        rd2_d      = rd2_q;
        wb_data2_d = wb_data2_q;
        wb_we2_d   = 1'b0;
        if (n_pop_c != 2'd0) begin
            wb_we1_d   = 1'b1;
            rd1_d      = rd_mem_q[rd_ptr_q];
            wb_data1_d = data_mem_q[rd_ptr_q];
        end
        if (n_pop_c == 2'd2) begin
            wb_we2_d   = 1'b1;
            rd2_d      = rd_mem_q[head1_c];
            wb_data2_d = data_mem_q[head1_c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd1_q      <= '0;
            wb_data1_q <= '0;
            wb_we1_q   <= 1'b0;
            rd2_q      <= '0;
            wb_data2_q <= '0;
            wb_we2_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd1_q      <= rd1_d;
            wb_data1_q <= wb_data1_d;
            wb_we1_q   <= wb_we1_d;
            rd2_q      <= rd2_d;
            wb_data2_q <= wb_data2_d;
            wb_we2_q   <= wb_we2_d;
        end
    end

    // Entry storage; live lanes are compacted, lane 0 first
    always_ff @(posedge clk) begin
        if (push_en_c && live0_c) begin
            rd_mem_q[wr_ptr_q]   <= in0_rd;
            data_mem_q[wr_ptr_q] <= in0_data;
        end
        if (push_en_c && live1_c) begin
            rd_mem_q[slot1_c]   <= in1_rd;
            data_mem_q[slot1_c] <= in1_data;
        end
    end

`ifdef WB_FWD_EN
    logic [1:0][AW-1:0] q_rs_c;
    logic [1:0]         q_hit_c;
    logic [1:0][DW-1:0] q_data_c;
    logic [PW-1:0]      q_idx_c;

    assign q_rs_c  = {q_rs2, q_rs1};
    assign q_hit1  = q_hit_c[0];
    assign q_hit2  = q_hit_c[1];
    assign q_data1 = q_data_c[0];
    assign q_data2 = q_data_c[1];

    // Later matches override earlier ones: port 1, port 2, then buffer oldest to youngest
    always_comb begin
        q_hit_c  = '0;
        q_data_c = '0;
        q_idx_c  = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            if (q_rs_c[k] != '0) begin
                if (wb_we1_q && (rd1_q == q_rs_c[k])) begin
                    q_hit_c[k]  = 1'b1;
                    q_data_c[k] = wb_data1_q;
                end
                if (wb_we2_q && (rd2_q == q_rs_c[k])) begin
                    q_hit_c[k]  = 1'b1;
                    q_data_c[k] = wb_data2_q;
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    q_idx_c = rd_ptr_q + PW'(i);
                    if ((CW'(i) < count_q) && (rd_mem_q[q_idx_c] == q_rs_c[k])) begin
                        q_hit_c[k]  = 1'b1;
                        q_data_c[k] = data_mem_q[q_idx_c];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: doc/wb_commit_buffer.md
Name: wb_commit_buffer

Overview:
- In-order writeback buffer in front of the dual-write-port register file.
- Accepts up to two completed results per cycle from the two execution lanes (lane 0 older) and queues them in program order.
- Drains up to two entries per cycle onto the register file write ports (rd1/wb_data1/wb_we1, rd2/wb_data2/wb_we2).
- Never issues two writes to the same rd in one cycle, so older-before-younger write order is always preserved.

Parameters:
- DEPTH, 8, buffer entries; power of two, ≥4.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in0_valid  in  1  lane 0 (older) result valid.
- in0_we  in  1  lane 0 writes a register.
- in0_rd  in  AW  lane 0 destination.
- in0_data  in  DW  lane 0 result.
- in1_valid  in  1  lane 1 (younger) result valid.
- in1_we  in  1  lane 1 writes a register.
- in1_rd  in  AW  lane 1 destination.
- in1_data  in  DW  lane 1 result.
- in_ready  out  1  buffer can accept both lanes this cycle.
- hold  in  1  suppress draining (pops) while high.
- rd1  out  AW  write port 1 address (registered).
- wb_data1  out  DW  write port 1 data (registered).
- wb_we1  out  1  write port 1 enable (registered).
- rd2  out  AW  write port 2 address (registered).
- wb_data2  out  DW  write port 2 data (registered).
- wb_we2  out  1  write port 2 enable (registered).
- count  out  $clog2(DEPTH)+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (async) clears read/write pointers and count. rd1, rd2, wb_data1, wb_data2, wb_we1, wb_we2 all go to 0, empty=1, full=0, in_ready=1. Reset mid-operation discards all buffered entries.
- Input filter: a lane is "live" when valid && we && rd≠0. Non-live lanes are dropped and never enqueued.
- in_ready = (DEPTH − count) ≥ 2, computed from registered count only (conservative; same-cycle pops are ignored).
- Push happens at a posedge when in_ready=1.
  - Live lanes are written at consecutive slots from the write pointer, lane 0 first, compacted.
  - The write pointer and count advance by the number of live lanes (0..2).
  - When in_ready=0, inputs are ignored; upstream must hold them.
- Pop decision uses registered state only and happens each posedge when hold=0:
  - count≥2 and head.rd ≠ (head+1).rd: pop 2. Head goes to port 1, head+1 goes to port 2.
  - count≥2 and rds equal: pop 1. Head goes to port 1; wb_we2=0.
  - count==1: pop 1 to port 1; wb_we2=0.
  - count==0 or hold=1: pop 0; wb_we1=wb_we2=0.
- Outputs are registered and hold the popped entries for exactly one cycle. The register file commits them at the following edge. Ports with we=0 keep their last rd/data values (don't care).
- Latency: a result pushed at edge N is popped at edge N+1 at the earliest, so wb_we is high during cycle N+1..N+2.
- Simultaneous push and pop in one cycle is allowed: count_next = count + pushed − popped.
- Pointers wrap modulo DEPTH.
- Ordering: entries drain strictly FIFO. Port 1 is always older than port 2.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds ports q_rs1, q_rs2 (in, AW), q_hit1, q_hit2 (out, 1), and q_data1, q_data2 (out, DW).
  - Purely combinational lookup of the youngest valid buffer entry whose rd matches.
  - Includes entries currently driven on the output registers with wb_we set; those rank older than any buffered entry.
  - q_hit=0 when q_rs==0 or there is no match; q_data is then 0.
- Not defined: no query ports and no lookup logic.

Test Plan:
- Push 3 entries with hold=1, then assert rst mid-cycle → immediately count=0, empty=1, in_ready=1, wb_we1=wb_we2=0. After release, no stale writes appear.
- Single push lane0 rd=5 data=0xDEADBEEF → one cycle later wb_we1=1, rd1=5, wb_data1=0xDEADBEEF, wb_we2=0, for exactly one cycle.
- Dual push rd=3/0x11 (lane0), rd=4/0x22 (lane1) → in the same single cycle port1=3/0x11 and port2=4/0x22, both enables high.
- WAW: same-cycle push rd=7/0xAAAA (lane0), rd=7/0xBBBB (lane1) → cycle k port1=7/0xAAAA with wb_we2=0, cycle k+1 port1=7/0xBBBB. Register 7 ends at 0xBBBB.
- Filter: lane0 rd=0 we=1 valid, lane1 rd=9 we=0 valid → nothing enqueued, count stays 0, no write-port activity.
- Full: DEPTH=8, hold=1, push 4 live pairs → count=8, full=1, in_ready=0, further pushes ignored. Drop hold → 4 cycles of dual writes in push order, then empty=1.
